stream_ram_writer: RTL and testbench



---
 rtl/stream_ram_writer_if.sv | 14 +
 rtl/stream_ram_writer.sv | 121 ++++++++++++
 tb/tb_stream_ram_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_ram_writer_if.sv
// Purpose: valid/ready word stream from a producer into stream_ram_writer.
// Latency: none; this is a signal bundle only.
// Backpressure: the producer holds in_valid/in_data until it sees in_ready high on an edge.
// Ports: in_valid, in_data (producer -> writer), in_ready (writer -> producer).
interface stream_ram_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/stream_ram_writer.sv
// Purpose: stores a stream of words into an internal RAM at auto-incrementing addresses from a
//          programmed base for a programmed word count; registered random-access read port.
// Latency: a word is written on the edge it is accepted; rd_data is valid 1 cycle after rd_addr.
// Backpressure: in_ready is high only in WRITE; an idle producer (in_valid=0) just stalls the burst.
// Ports: clk/rst (sync, active-high); start/base_addr/length burst request; in_if stream slave;
//        busy/done/wr_addr_out/word_count status; rd_addr/rd_data read-first read port.
module stream_ram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  stream_ram_writer_if.slave    in_if,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [ADDR_WIDTH:0]   word_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic wr_en;

  // Reset blocks the write on the reset edge itself so an abandoned burst leaves RAM untouched.
  assign wr_en = (state_q == WRITE) && in_if.in_valid && !rst;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    word_count_d = word_count_q;
    wr_addr_d    = wr_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d        = base_addr;
          remaining_d  = length;
          word_count_d = '0;
          state_d      = (length == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (in_if.in_valid) begin
          wr_addr_d    = ptr_q;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);  // wraps at the top of the RAM
          word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
          remaining_d  = remaining_q - (ADDR_WIDTH+1)'(1);
          if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Asynchronous array read feeding the output register; the write below uses <=, so a
  // same-edge read of the written address returns the old word.
  always_comb begin
    rd_data_d = ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      word_count_q <= '0;
      wr_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      word_count_q <= word_count_d;
      wr_addr_q    <= wr_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // RAM contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[ptr_q] <= in_if.in_data;
    end
  end

  assign in_if.in_ready = (state_q == WRITE);
  assign busy           = (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign wr_addr_out    = wr_addr_q;
  assign word_count     = word_count_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_stream_ram_writer.sv
// Purpose: self-checking bench for stream_ram_writer with a burst-level reference model.
// Latency: model predicts outputs after each rising edge; read data one cycle after address.
// Backpressure: bench drives in_valid patterns including gaps; block never stalls the producer otherwise.
module tb_stream_ram_writer;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] wr_addr_out;
  logic [AW:0]   word_count;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  stream_ram_writer_if #(.DATA_WIDTH(DW)) s_if ();

  stream_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .in_if       (s_if),
    .busy        (busy),
    .done        (done),
    .wr_addr_out (wr_addr_out),
    .word_count  (word_count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- burst-level reference model ----------------
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_active;      // inside a burst, accepting words
  bit            m_done;        // the one-cycle completion slot
  int            m_left;
  int            m_next;
  int            m_wc;
  int            m_wa;
  int            m_rd;
  bit            m_rd_known;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_active = 0; m_done = 0; m_left = 0; m_next = 0;
    m_wc = 0; m_wa = 0; m_rd = 0; m_rd_known = 1'b1;
  end

  always @(posedge clk) begin
    bit was_done;
    if (rst) begin
      m_rd = 0; m_rd_known = 1'b1;
      m_active = 0; m_done = 0; m_wc = 0; m_wa = 0;
    end else begin
      m_rd       = int'(m_mem[int'(rd_addr)]);
      m_rd_known = m_known[int'(rd_addr)];
      was_done   = m_done;
      m_done     = 0;
      if (m_active) begin
        if (s_if.in_valid) begin
          m_mem[m_next]   = s_if.in_data;
          m_known[m_next] = 1'b1;
          m_wa   = m_next;
          m_next = (m_next + 1) % DEPTH;
          m_wc++;
          m_left--;
          if (m_left == 0) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (!was_done && start) begin
        m_next = int'(base_addr);
        m_left = int'(length);
        m_wc   = 0;
        if (m_left == 0) m_done = 1;
        else             m_active = 1;
      end
    end
  end

  // Compare every cycle, shortly after the edge.
  always @(posedge clk) begin
    #2;
    chk("busy",        int'(busy),        int'(m_active));
    chk("in_ready",    int'(s_if.in_ready), int'(m_active));
    chk("done",        int'(done),        int'(m_done));
    chk("word_count",  int'(word_count),  m_wc);
    chk("wr_addr_out", int'(wr_addr_out), m_wa);
    if (m_rd_known) chk("rd_data", int'(rd_data), m_rd);
  end

  int done_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (done) done_cnt++;
  end

  // ---------------- stimulus helpers (all start and end on a negedge) ----------------
  int ready_cnt = 0;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 7 + 3);
  endfunction

  task automatic do_start(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d);
    s_if.in_valid = v;
    s_if.in_data  = d;
    if (s_if.in_ready) ready_cnt++;
    @(negedge clk);
  endtask

  task automatic rd_expect(input string name, input int a, input int exp);
    rd_addr = AW'(a);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    s_if.in_valid = 1'b0; s_if.in_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset busy",       int'(busy), 0);
    chk("reset done",       int'(done), 0);
    chk("reset in_ready",   int'(s_if.in_ready), 0);
    chk("reset word_count", int'(word_count), 0);
    chk("reset wr_addr",    int'(wr_addr_out), 0);
    chk("reset rd_data",    int'(rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-depth burst: every location written exactly once, pointer wraps to end at 1023.
    do_start(0, DEPTH);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, pat(i));
    s_if.in_valid = 1'b0;
    chk("full done",       int'(done), 1);
    chk("full word_count", int'(word_count), 1024);
    chk("full wr_addr",    int'(wr_addr_out), 1023);
    @(negedge clk);
    rd_expect("full rd 5",   5,   8'h26);
    rd_expect("full rd 700", 700, int'(pat(700)));

    // Test 1: base 0, four words, valid held high.
    do_start(0, 4);
    ready_cnt = 0;
    cyc(1'b1, 8'h11); cyc(1'b1, 8'h22); cyc(1'b1, 8'h33); cyc(1'b1, 8'h44);
    s_if.in_valid = 1'b0;
    chk("t1 ready cycles", ready_cnt, 4);
    chk("t1 done",         int'(done), 1);
    chk("t1 ready low",    int'(s_if.in_ready), 0);
    chk("t1 word_count",   int'(word_count), 4);
    chk("t1 wr_addr",      int'(wr_addr_out), 3);
    @(negedge clk);
    rd_expect("t1 rd 0", 0, 8'h11);
    rd_expect("t1 rd 1", 1, 8'h22);
    rd_expect("t1 rd 2", 2, 8'h33);
    rd_expect("t1 rd 3", 3, 8'h44);

    // Test 2: address wrap from 1023 to 0.
    do_start(1022, 4);
    cyc(1'b1, 8'hA0); cyc(1'b1, 8'hA1); cyc(1'b1, 8'hA2); cyc(1'b1, 8'hA3);
    s_if.in_valid = 1'b0;
    chk("t2 wr_addr", int'(wr_addr_out), 1);
    @(negedge clk);
    rd_expect("t2 rd 1022", 1022, 8'hA0);
    rd_expect("t2 rd 1023", 1023, 8'hA1);
    rd_expect("t2 rd 0",    0,    8'hA2);
    rd_expect("t2 rd 1",    1,    8'hA3);
    rd_expect("t2 rd 2",    2,    8'h33);

    // Test 3: valid gaps stall the burst.
    done_cnt = 0;
    do_start(10, 3);
    cyc(1'b1, 8'hB0);
    cyc(1'b0, 8'hB1);
    chk("t3 busy in gap", int'(busy), 1);
    cyc(1'b0, 8'hB2);
    cyc(1'b1, 8'hB3);
    cyc(1'b1, 8'hB4);
    s_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3 done count", done_cnt, 1);
    chk("t3 word_count", int'(word_count), 3);
    rd_expect("t3 rd 10", 10, 8'hB0);
    rd_expect("t3 rd 11", 11, 8'hB3);
    rd_expect("t3 rd 12", 12, 8'hB4);
    rd_expect("t3 rd 13", 13, 8'h5E);

    // Test 4: zero-length burst.
    do_start(20, 0);
    chk("t4 done",       int'(done), 1);
    chk("t4 busy",       int'(busy), 0);
    chk("t4 word_count", int'(word_count), 0);
    @(negedge clk);
    rd_expect("t4 rd 20", 20, 8'h8F);

    // Test 5: reset after two of five words.
    do_start(30, 5);
    cyc(1'b1, 8'hC0); cyc(1'b1, 8'hC1);
    rst = 1'b1; s_if.in_valid = 1'b1; s_if.in_data = 8'hC2;
    @(negedge clk);
    chk("t5 busy",       int'(busy), 0);
    chk("t5 word_count", int'(word_count), 0);
    chk("t5 in_ready",   int'(s_if.in_ready), 0);
    rst = 1'b0; s_if.in_valid = 1'b0;
    @(negedge clk);
    rd_expect("t5 rd 30", 30, 8'hC0);
    rd_expect("t5 rd 31", 31, 8'hC1);
    rd_expect("t5 rd 32", 32, 8'hE3);

    // Test 6: start while busy is ignored; read-first on a same-edge write.
    do_start(40, 3);
    start = 1'b1; base_addr = AW'(100); length = '0;
    cyc(1'b1, 8'hD0);
    start = 1'b0;
    rd_addr = AW'(41);
    cyc(1'b1, 8'hD1);
    chk("t6 read-first old", int'(rd_data), 8'h22);
    cyc(1'b1, 8'hD2);
    s_if.in_valid = 1'b0;
    chk("t6 read new",     int'(rd_data), 8'hD1);
    chk("t6 done",         int'(done), 1);
    chk("t6 word_count",   int'(word_count), 3);
    chk("t6 wr_addr",      int'(wr_addr_out), 42);
    // start during the DONE cycle is ignored as well
    do_start(200, 2);
    chk("t6 start in done ignored", int'(busy), 0);
    @(negedge clk);
    chk("t6 still idle", int'(busy), 0);
    rd_expect("t6 rd 100", 100, 8'hBF);
    rd_expect("t6 rd 42",  42,  8'hD2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
